// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of {pc, instr} pairs with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  output logic                         valid,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign do_pop  = pop && valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding memory request, output FIFO.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            fetch_fault
`endif
);

  localparam int unsigned     CW         = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] issued_pc;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            issue;
  logic            halted;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign mem_addr  = fetch_pc;
  assign issue     = mem_req && mem_gnt;
  assign pop       = instr_valid && instr_ready;
  assign push_data = '{pc: issued_pc, instr: mem_rdata};
  assign instr     = instr_valid ? head.instr : INSTR_NOP;
  assign instr_pc  = head.pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset)               halted <= 1'b0;
    else if (redirect_valid) halted <= |redirect_pc[1:0];
  end
  assign fetch_fault = halted;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    push       = 1'b0;
    case (state)
      FETCH: begin
        mem_req = !reset && !redirect_valid && !halted && (count < CW'(DEPTH));
        if (mem_req && mem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          push       = !redirect_valid;
          state_next = FETCH;
        end else if (redirect_valid) begin
          state_next = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_rvalid) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      issued_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (issue)     fetch_pc <= fetch_pc + 32'd4;
      if (issue) issued_pc <= fetch_pc;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .valid    (instr_valid),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          NCYC     = 3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault   (fetch_fault)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  bit   started = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0100;
      1:       return 32'hFFFF_FFF8;
      2:       return r & 32'h0000_FFFC;
      3:       return 32'h0000_0102;
      4:       return 32'h0000_0200;
      default: return r;
    endcase
  endfunction

  // Monitor: every cycle the head must match the oldest undelivered, unflushed response.
  always @(negedge clk) begin
    if (started) begin
      chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (instr_valid && exp_q.size() != 0) begin
        chk("instr_pc", instr_pc, exp_q[0].pc);
        chk("instr", instr, exp_q[0].data);
        if (instr_ready) begin
          void'(exp_q.pop_front());
          delivered++;
        end
      end
    end
  end

  // Reference model state: transaction-level view of the fetch stream.
  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  bit          outstanding;
  bit          stale;
  bit          halted_m;
  bit          exp_req;
  bit          mem_busy;
  int          mem_wait;
  int          ready_pct;
  bit          rst_d, redir_d, rvalid_d, gnt_d;
  logic [31:0] tgt_d, rdata_d;

  initial begin
    exp_pc = RESET_PC; pend_addr = '0;
    outstanding = 0; stale = 0; halted_m = 0; mem_busy = 0; mem_wait = 0;
    rst_d = 1; redir_d = 0; rvalid_d = 0; gnt_d = 0; tgt_d = '0; rdata_d = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      // Fold the effects of the cycle that just ended into the model.
      if (rst_d) begin
        exp_q.delete();
        outstanding = 0; stale = 0; halted_m = 0;
        exp_pc = RESET_PC;
      end else begin
        if (redir_d) begin
          exp_q.delete();
          exp_pc = {tgt_d[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
          halted_m = (tgt_d[1:0] != 2'b00);
`endif
        end
        if (rvalid_d && outstanding) begin
          if (!stale && !redir_d) exp_q.push_back('{pc: pend_addr, data: rdata_d});
          outstanding = 0;
          stale = 0;
        end else if (redir_d && outstanding) begin
          stale = 1;
        end
        if (gnt_d) begin
          outstanding = 1;
          pend_addr = exp_pc;
          exp_pc = exp_pc + 32'd4;
        end
      end
      started = 1;

      #1;
      reset = (cyc < 2) || (cyc >= 1500 && cyc < 1502);
      case ((cyc / 100) % 4)
        0:       ready_pct = 100;
        1:       ready_pct = 0;
        2:       ready_pct = 50;
        default: ready_pct = 20;
      endcase
      instr_ready = ($urandom_range(0, 99) < ready_pct);
      mem_gnt     = ($urandom_range(0, 2) != 0);
      mem_rvalid  = 1'b0;
      redirect_valid = 1'b0;
      if (reset) begin
        mem_busy = 0;
      end else begin
        redirect_valid = !redir_d && ($urandom_range(0, 13) == 0);
        redirect_pc    = pick_target();
        if (mem_busy) begin
          mem_wait--;
          if (mem_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            mem_busy   = 0;
          end
        end
      end

      #1;
      exp_req = !reset && !outstanding && !redirect_valid && !halted_m && (exp_q.size() < DEPTH);
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      if (exp_req) chk("mem_addr", mem_addr, exp_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_fault", 32'(fetch_fault), 32'(halted_m));
`endif
      gnt_d = exp_req && mem_gnt;
      if (gnt_d) begin
        mem_busy = 1;
        mem_wait = $urandom_range(1, 4);
      end
      rst_d    = reset;
      redir_d  = redirect_valid;
      tgt_d    = redirect_pc;
      rvalid_d = mem_rvalid;
      rdata_d  = mem_rdata;
    end

    @(negedge clk);
    checks++;
    if (delivered < 50) begin
      errors++;
      $display("FAIL throughput: delivered %0d instructions, required at least 50", delivered);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
